conv_row_sequencer: RTL and testbench

- Hardware master for the 3-PE column custom instruction. It replaces the Nios II software loop that issues reset, send-weight, send-input, send-output and get-result commands.
- Accepts a 3-tap kernel and a raster pixel stream. Forms 3-pixel sliding windows within each row, drives the custom-instruction slave port, and streams one result per window downstream.
- Windows never span a row boundary.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_window3.sv | 65 ++++++
 rtl/conv_row_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_conv_row_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3-PE column row sequencer.
//   - CI_* : opcodes placed on ci_n when issuing a custom-instruction command.
//   - conv_state_e : sequencer state encoding.
package conv_pkg;

  localparam logic [2:0] CI_RESET  = 3'd0;
  localparam logic [2:0] CI_SEND_W = 3'd1;
  localparam logic [2:0] CI_SEND_I = 3'd2;
  localparam logic [2:0] CI_SEND_O = 3'd3;
  localparam logic [2:0] CI_GET_R  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD_W = 3'd2,
    FILL   = 3'd3,
    SEND_I = 3'd4,
    SEND_O = 3'd5,
    GET_R  = 3'd6,
    OUT    = 3'd7
  } conv_state_e;

endpackage

// File: rtl/conv_window3.sv
// 3-deep pixel shift window with its column (fill) counter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the column counter (frame start / row end)
//   shift      : accept din: w0<-w1, w1<-w2, w2<-din, col_cnt+1
//   w0..w2     : current window, w0 is the oldest pixel
//   col_cnt    : pixels accepted in the current row
module conv_window3 #(
  parameter int DataWidth = 32,
  parameter int RowLen    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift,
  input  logic [DataWidth-1:0]          din,
  output logic [DataWidth-1:0]          w0,
  output logic [DataWidth-1:0]          w1,
  output logic [DataWidth-1:0]          w2,
  output logic [$clog2(RowLen+1)-1:0]   col_cnt
);

  localparam int ColW = $clog2(RowLen + 1);

  logic [DataWidth-1:0] w0_q, w0_d;
  logic [DataWidth-1:0] w1_q, w1_d;
  logic [DataWidth-1:0] w2_q, w2_d;
  logic [ColW-1:0]      col_cnt_q, col_cnt_d;

  always_comb begin
    w0_d      = w0_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    col_cnt_d = col_cnt_q;
    if (clear) begin
      // Stale window contents are harmless: three fresh pixels are
      // always shifted in before the next window is used.
      col_cnt_d = '0;
    end else if (shift) begin
      w0_d      = w1_q;
      w1_d      = w2_q;
      w2_d      = din;
      col_cnt_d = col_cnt_q + ColW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w0_q      <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      col_cnt_q <= '0;
    end else begin
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  assign w0      = w0_q;
  assign w1      = w1_q;
  assign w2      = w2_q;
  assign col_cnt = col_cnt_q;

endmodule

// File: rtl/conv_row_sequencer.sv
// Hardware master for the 3-PE column custom instruction. Loads a 3-tap
// kernel, forms 3-pixel windows within each row of a raster stream, runs
// each window through the PE column and streams one result per window.
//   clk, reset                 : clock, synchronous active-high reset
//   go                         : frame start pulse (IDLE only)
//   k_valid/k_ready/k_data     : kernel words tap0, tap1, tap2
//   px_valid/px_ready/px_data  : raster pixel stream
//   ci_start/ci_n/ci_dataa     : command to PE column, held until ci_done
//   ci_done/ci_result          : PE column response
//   res_valid/res_ready/res_data : result stream
//   busy                       : not IDLE
//   frame_done                 : pulse after the frame's last result is taken
module conv_row_sequencer #(
  parameter int DataWidth = 32,
  parameter int RowLen    = 8,
  parameter int NumRows   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 k_valid,
  output logic                 k_ready,
  input  logic [DataWidth-1:0] k_data,
  input  logic                 px_valid,
  output logic                 px_ready,
  input  logic [DataWidth-1:0] px_data,
  output logic                 ci_start,
  output logic [2:0]           ci_n,
  output logic [DataWidth-1:0] ci_dataa,
  input  logic                 ci_done,
  input  logic [DataWidth-1:0] ci_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DataWidth-1:0] res_data,
  output logic                 busy,
  output logic                 frame_done
);

  import conv_pkg::*;

  localparam int ColW = $clog2(RowLen + 1);
  localparam int RowW = $clog2(NumRows + 1);

  conv_state_e          state_q, state_d;
  logic [1:0]           sub_q, sub_d;        // word index within LOAD_W / SEND_I
  logic [RowW-1:0]      row_q, row_d;
  logic [DataWidth-1:0] res_data_q, res_data_d;
  logic                 frame_done_q, frame_done_d;

  logic                 win_clear;
  logic                 win_shift;
  logic [DataWidth-1:0] w0, w1, w2;
  logic [ColW-1:0]      col_cnt;
  logic [ColW:0]        col_after;
  logic [RowW-1:0]      row_inc;

  conv_window3 #(
    .DataWidth (DataWidth),
    .RowLen    (RowLen)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .clear   (win_clear),
    .shift   (win_shift),
    .din     (px_data),
    .w0      (w0),
    .w1      (w1),
    .w2      (w2),
    .col_cnt (col_cnt)
  );

  // Column count as it will be after the pixel accepted this cycle.
  assign col_after = {1'b0, col_cnt} + {{ColW{1'b0}}, 1'b1};
  assign row_inc   = row_q + RowW'(1);

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    row_d        = row_q;
    res_data_d   = res_data_q;
    frame_done_d = 1'b0;
    win_clear    = 1'b0;
    win_shift    = 1'b0;
    ci_start     = 1'b0;
    ci_n         = CI_RESET;
    ci_dataa     = '0;
    k_ready      = 1'b0;
    px_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = RST;
          sub_d     = '0;
          row_d     = '0;
          win_clear = 1'b1;
        end
      end

      RST: begin
        ci_start = 1'b1;
        ci_n     = CI_RESET;
        if (ci_done) begin
          state_d = LOAD_W;
          sub_d   = '0;
        end
      end

      LOAD_W: begin
        // The kernel word rides straight through to the PE column and is
        // only consumed in the cycle the PE completes the command.
        k_ready = ci_done;
        if (k_valid) begin
          ci_start = 1'b1;
          ci_n     = CI_SEND_W;
          ci_dataa = k_data;
          if (ci_done) begin
            if (sub_q == 2'd2) begin
              state_d = FILL;
              sub_d   = '0;
            end else begin
              sub_d = sub_q + 2'd1;
            end
          end
        end
      end

      FILL: begin
        px_ready = 1'b1;
        if (px_valid) begin
          win_shift = 1'b1;
          if (col_after >= (ColW + 1)'(3)) begin
            state_d = SEND_I;
            sub_d   = '0;
          end
        end
      end

      SEND_I: begin
        ci_start = 1'b1;
        ci_n     = CI_SEND_I;
        case (sub_q)
          2'd0:    ci_dataa = w0;
          2'd1:    ci_dataa = w1;
          default: ci_dataa = w2;
        endcase
        if (ci_done) begin
          if (sub_q == 2'd2) begin
            state_d = SEND_O;
            sub_d   = '0;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end

      SEND_O: begin
        ci_start = 1'b1;
        ci_n     = CI_SEND_O;
        if (ci_done) state_d = GET_R;
      end

      GET_R: begin
        // n=4 pops the accumulator, so it is only ever driven here.
        ci_start = 1'b1;
        ci_n     = CI_GET_R;
        if (ci_done) begin
          res_data_d = ci_result;
          state_d    = OUT;
        end
      end

      OUT: begin
        if (res_ready) begin
          state_d = FILL;
          if (col_cnt == ColW'(RowLen)) begin
            win_clear = 1'b1;
            row_d     = row_inc;
            if (row_inc == RowW'(NumRows)) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sub_q        <= '0;
      row_q        <= '0;
      res_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      row_q        <= row_d;
      res_data_q   <= res_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign res_valid  = (state_q == OUT);
  assign res_data   = res_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Self-checking bench for conv_row_sequencer with a behavioural PE-column stub.
module tb_conv_row_sequencer;

  localparam int DW = 32;
  localparam int RL = 8;
  localparam int NR = 2;
  localparam int NPX = RL * NR;
  localparam int NRES = (RL - 2) * NR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          k_valid = 1'b0;
  logic          k_ready;
  logic [DW-1:0] k_data = '0;
  logic          px_valid = 1'b0;
  logic          px_ready;
  logic [DW-1:0] px_data = '0;
  logic          ci_start;
  logic [2:0]    ci_n;
  logic [DW-1:0] ci_dataa;
  logic          ci_done;
  logic [DW-1:0] ci_result;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_row_sequencer #(.DataWidth(DW), .RowLen(RL), .NumRows(NR)) dut (
    .clk(clk), .reset(reset), .go(go),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .ci_start(ci_start), .ci_n(ci_n), .ci_dataa(ci_dataa),
    .ci_done(ci_done), .ci_result(ci_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- PE column stub ----------------
  logic [DW-1:0] st_w [3];
  logic [DW-1:0] st_x [3];
  int            st_wi, st_xi;
  logic [DW-1:0] st_acc;
  int            get_wait;
  int            get_delay = 0;
  int            n2_cnt;
  logic [2:0]    last_n;
  logic [34:0]   trace_q[$];

  assign ci_done   = ci_start && ((ci_n != 3'd4) || (get_wait >= get_delay));
  assign ci_result = st_acc;

  always @(posedge clk) begin
    if (reset) begin
      st_wi <= 0; st_xi <= 0; st_acc <= '0; get_wait <= 0; n2_cnt <= 0; last_n <= 3'd0;
    end else if (ci_start && ci_done) begin
      get_wait <= 0;
      last_n   <= ci_n;
      trace_q.push_back({ci_n, (ci_n == 3'd4) ? 32'd0 : ci_dataa});
      case (ci_n)
        3'd0: begin st_wi <= 0; st_xi <= 0; st_acc <= '0; n2_cnt <= 0; end
        3'd1: begin st_w[st_wi] <= ci_dataa; st_wi <= (st_wi + 1) % 3; end
        3'd2: begin st_x[st_xi] <= ci_dataa; st_xi <= (st_xi + 1) % 3; n2_cnt <= n2_cnt + 1; end
        3'd3: st_acc <= ci_dataa + st_w[0] * st_x[0] + st_w[1] * st_x[1] + st_w[2] * st_x[2];
        default: ;
      endcase
    end else if (ci_start && ci_n == 3'd4) begin
      get_wait <= get_wait + 1;
    end
  end

  // ---------------- protocol monitor ----------------
  int viol_idle, viol_n4, viol_px, fd_cnt;
  always @(negedge clk) begin
    if (!reset) begin
      if (!ci_start && (ci_n != 3'd0 || ci_dataa != '0)) viol_idle <= viol_idle + 1;
      if (ci_n == 3'd4 && last_n != 3'd3) viol_n4 <= viol_n4 + 1;
      if (px_ready && (res_valid || ci_start)) viol_px <= viol_px + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
    end
  end

  // ---------------- stimulus data ----------------
  logic [DW-1:0] kern[3];
  logic [DW-1:0] pix[NPX];
  logic [DW-1:0] got_q[$];

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic send_k(input logic [DW-1:0] d);
    bit hs = 0;
    k_valid = 1'b1; k_data = d;
    for (int c = 0; c < 2000 && !hs; c++) begin
      @(negedge clk); hs = k_valid && k_ready;
      @(posedge clk); #1;
    end
    if (!hs) check_eq("k_timeout", 1, 0);
    k_valid = 1'b0;
  endtask

  task automatic send_px(input logic [DW-1:0] d);
    bit hs = 0;
    px_valid = 1'b1; px_data = d;
    for (int c = 0; c < 2000 && !hs; c++) begin
      @(negedge clk); hs = px_valid && px_ready;
      @(posedge clk); #1;
    end
    if (!hs) check_eq("px_timeout", 1, 0);
    px_valid = 1'b0;
  endtask

  task automatic run_frame(input int gdelay, input int low_hold, input bit mid_go);
    logic [DW-1:0] exp_q[$];
    logic [34:0]   exp_tr[$];
    int mism;
    get_delay = gdelay;
    got_q.delete();
    trace_q.delete();
    viol_idle = 0; viol_n4 = 0; viol_px = 0; fd_cnt = 0;
    // reference: dot product per window, windows confined to rows
    exp_tr.push_back({3'd0, 32'd0});
    for (int t = 0; t < 3; t++) exp_tr.push_back({3'd1, kern[t]});
    for (int r = 0; r < NR; r++)
      for (int j = 0; j <= RL - 3; j++) begin
        exp_q.push_back(kern[0] * pix[r*RL+j] + kern[1] * pix[r*RL+j+1] + kern[2] * pix[r*RL+j+2]);
        for (int t = 0; t < 3; t++) exp_tr.push_back({3'd2, pix[r*RL+j+t]});
        exp_tr.push_back({3'd3, 32'd0});
        exp_tr.push_back({3'd4, 32'd0});
      end
    pulse_go();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
          send_k(kern[i]);
        end
        k_valid = 1'b1; k_data = 32'hDEAD_BEEF;   // stray word, must be ignored
      end
      begin
        for (int i = 0; i < NPX; i++) begin
          repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
          send_px(pix[i]);
        end
      end
      begin
        int idx = 0;
        int hold_left = low_hold;
        int hold_bad = 0;
        for (int c = 0; c < 20000 && idx < NRES; c++) begin
          res_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(3, 0) != 0);
          @(negedge clk);
          if (res_valid && hold_left > 0) begin
            if (px_ready || !res_valid) hold_bad++;
            hold_left--;
          end else if (res_valid && res_ready) begin
            check_eq($sformatf("res%0d", idx), res_data, exp_q[idx]);
            got_q.push_back(res_data);
            idx++;
          end
          @(posedge clk); #1;
        end
        if (idx < NRES) check_eq("res_timeout", idx, NRES);
        if (low_hold > 0) check_eq("hold_stable", hold_bad, 0);
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("frame_done_pulse", frame_done, 1);
        check_eq("idle_after_frame", busy, 0);
        @(negedge clk);
        check_eq("frame_done_one_cycle", frame_done, 0);
      end
      begin
        if (mid_go) begin
          bit seen = 0;
          for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = ci_start && ci_n == 3'd2;
          end
          go = 1'b1;
          @(posedge clk); #1;
          go = 1'b0;
        end
      end
    join
    k_valid = 1'b0;
    px_valid = 1'b0;
    @(posedge clk); #1;
    mism = 0;
    for (int i = 0; i < exp_tr.size() && i < trace_q.size(); i++)
      if (trace_q[i] !== exp_tr[i]) mism++;
    check_eq("trace_len", trace_q.size(), exp_tr.size());
    check_eq("trace_content", mism, 0);
    check_eq("ci_idle_clean", viol_idle, 0);
    check_eq("n4_outside_getr", viol_n4, 0);
    check_eq("px_ready_while_busy", viol_px, 0);
    check_eq("frame_done_count", fd_cnt, 1);
    $display("frame gdelay=%0d hold=%0d mid_go=%0d results=%0d", gdelay, low_hold, mid_go, got_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {ci_start, ci_n, ci_dataa, k_ready, px_ready, res_valid, res_data, busy, frame_done}, 0);
  endtask

  task automatic load_directed();
    kern[0] = 1; kern[1] = 2; kern[2] = 3;
    for (int i = 0; i < RL; i++) begin
      pix[i]      = DW'(i + 1);
      pix[RL + i] = DW'(i + 10);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;

    // directed frame: 1,2,3 kernel, rows 1..8 and 10..17
    load_directed();
    run_frame(0, 0, 0);
    check_eq("row0_first", got_q.size() > 0 ? got_q[0] : 64'hX, 14);
    check_eq("row0_last", got_q.size() > 5 ? got_q[5] : 64'hX, 44);
    check_eq("row1_first", got_q.size() > 6 ? got_q[6] : 64'hX, 68);

    // slow GET_R, backpressure, go while busy
    run_frame(9, 5, 1);
    check_eq("slow_row1_first", got_q.size() > 6 ? got_q[6] : 64'hX, 68);

    // abort mid-window after second n=2 issue
    pulse_go();
    for (int i = 0; i < 3; i++) send_k(kern[i]);
    for (int i = 0; i < 3; i++) send_px(pix[i]);
    for (int c = 0; c < 200 && n2_cnt < 2; c++) @(negedge clk);
    check_eq("abort_reached_n2", n2_cnt, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("abort_outputs");
    reset = 1'b0;
    @(posedge clk); #1;
    $display("abort applied after second n=2 issue");
    run_frame(1, 0, 0);
    check_eq("post_abort_first", got_q.size() > 0 ? got_q[0] : 64'hX, 14);

    // random frames
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 3; t++) kern[t] = $urandom;
      for (int i = 0; i < NPX; i++) pix[i] = $urandom;
      run_frame($urandom_range(4, 0), $urandom_range(3, 0), f[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
